// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock and keeps the carry in a register between chunks. This keeps the
// critical path to one CHUNK-bit ripple add plus a mux.
module seq_chunk_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunk_sum;
    logic             carry_into_msb;

    // One CHUNK-bit slice of the add; operands are always consumed from the low end.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};

    // Carry into the top bit recovered from the top sum bit of the final slice.
    assign carry_into_msb = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    // Next-state logic: operand capture, per-chunk add, and final flag update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = carry_in ^ sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                carry_d = chunk_sum[CHUNK];
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CHUNK) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = carry_into_msb ^ chunk_sum[CHUNK];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and clears results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder. Three instances:
// 64/16 (main), 64/64 (single chunk) and 32/8 (random vs golden model).
module tb_seq_chunk_adder;

    typedef struct {
        int          idx;
        logic [63:0] sum;
        logic        co;
        logic        ov;
        int          exp_cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_w [3];
    logic [63:0] a_in    [3];
    logic [63:0] b_in    [3];
    logic        cin_w   [3];
    logic        sub_w   [3];
    logic        ready_w [3];
    logic        done_w  [3];
    logic        co_w    [3];
    logic        ov_w    [3];
    logic [63:0] sum_w   [3];
    logic [31:0] sum2;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   hs_prev;
    bit   hs_mode;
    logic prev_done [3];

    seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .ready(ready_w[0]),
        .a(a_in[0]), .b(b_in[0]), .carry_in(cin_w[0]), .sub(sub_w[0]),
        .sum(sum_w[0]), .carry_out(co_w[0]), .overflow(ov_w[0]), .done(done_w[0])
    );

    seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .ready(ready_w[1]),
        .a(a_in[1]), .b(b_in[1]), .carry_in(cin_w[1]), .sub(sub_w[1]),
        .sum(sum_w[1]), .carry_out(co_w[1]), .overflow(ov_w[1]), .done(done_w[1])
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .ready(ready_w[2]),
        .a(a_in[2][31:0]), .b(b_in[2][31:0]), .carry_in(cin_w[2]), .sub(sub_w[2]),
        .sum(sum2), .carry_out(co_w[2]), .overflow(ov_w[2]), .done(done_w[2])
    );

    assign sum_w[2] = {32'd0, sum2};

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check done latency and spacing.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nchunk(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // Golden model: {overflow, carry_out, sum} for a W-bit add or subtract.
    function automatic logic [65:0] golden(input int w, input logic [63:0] av,
                                           input logic [63:0] bv, input logic cv,
                                           input logic sv);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] s;
        logic [64:0] full;
        logic        co;
        logic        ov;
        mask = (64'h1 << w) - 64'h1;
        am   = av & mask;
        bm   = (sv ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, bm} + {64'd0, cv ^ sv};
        co   = full[w];
        s    = full[63:0] & mask;
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check_output(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait for ready, present one operation, and push its expected result.
    task automatic apply_stimulus(input int idx, input logic [63:0] av,
                                  input logic [63:0] bv, input logic cv,
                                  input logic sv, input logic [63:0] es,
                                  input logic ec, input logic eo,
                                  input string nm, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!ready_w[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[idx]) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s ready_timeout: got ready=0 expected ready=1", nm);
            return;
        end
        start_w[idx] = 1'b1;
        a_in[idx]    = av;
        b_in[idx]    = bv;
        cin_w[idx]   = cv;
        sub_w[idx]   = sv;
        if (push) begin
            e.idx     = idx;
            e.sum     = es;
            e.co      = ec;
            e.ov      = eo;
            e.exp_cyc = cyc + 1 + nchunk(idx);
            e.name    = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start_w[idx] = 1'b0;
        a_in[idx]    = ~av;
        b_in[idx]    = ~bv;
        cin_w[idx]   = ~cv;
        sub_w[idx]   = ~sv;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops the scoreboard whenever any instance presents done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    check_output("done_width", {63'd0, prev_done[i]}, 64'd0);
                    check_output("ready_during_done", {63'd0, ready_w[i]}, 64'd0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_done: got done on dut%0d expected none", i);
                    end else begin
                        e = sb.pop_front();
                        check_output({e.name, "_dut"}, 64'(i), 64'(e.idx));
                        check_output({e.name, "_sum"}, sum_w[i], e.sum);
                        check_output({e.name, "_carry"}, {63'd0, co_w[i]}, {63'd0, e.co});
                        check_output({e.name, "_ovf"}, {63'd0, ov_w[i]}, {63'd0, e.ov});
                        check_output({e.name, "_latency"}, 64'(cyc), 64'(e.exp_cyc));
                    end
                    if (hs_mode && i == 0) begin
                        if (hs_prev >= 0) begin
                            check_output("done_spacing", 64'(cyc - hs_prev), 64'd6);
                        end
                        hs_prev = cyc;
                    end
                end
                prev_done[i] = done_w[i];
            end
        end else begin
            for (int i = 0; i < 3; i++) prev_done[i] = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        logic [65:0] g;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        hs_prev  = -1;
        hs_mode  = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            a_in[i]    = '0;
            b_in[i]    = '0;
            cin_w[i]   = 1'b0;
            sub_w[i]   = 1'b0;
            prev_done[i] = 1'b0;
        end
        #2;
        check_output("reset_ready", {63'd0, ready_w[0]}, 64'd1);
        check_output("reset_done", {63'd0, done_w[0]}, 64'd0);
        check_output("reset_sum", sum_w[0], 64'd0);
        check_output("reset_carry", {63'd0, co_w[0]}, 64'd0);
        check_output("reset_ovf", {63'd0, ov_w[0]}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        apply_stimulus(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h0000_0001_0000_0000, 1'b0, 1'b0, "add_carry_chain", 1'b1);
        wait_drain();
        apply_stimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                       64'd0, 1'b1, 1'b0, "full_wrap", 1'b1);
        wait_drain();
        apply_stimulus(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h8000_0000_0000_0000, 1'b0, 1'b1, "signed_ovf", 1'b1);
        wait_drain();
        apply_stimulus(0, 64'd5, 64'd7, 1'b0, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_borrow", 1'b1);
        wait_drain();
        apply_stimulus(0, 64'd7, 64'd5, 1'b1, 1'b1,
                       64'd1, 1'b1, 1'b0, "sub_cin", 1'b1);
        wait_drain();
        apply_stimulus(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                       64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_ovf", 1'b1);
        wait_drain();

        // start held high with operands changing every cycle
        hs_mode = 1'b1;
        hs_prev = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start_w[0] = 1'b1;
            a_in[0]    = 64'h0000_1000_0000_0000 * k + 64'(k);
            b_in[0]    = 64'(k * 3);
            cin_w[0]   = k[0];
            sub_w[0]   = k[1];
            if (ready_w[0]) begin
                exp_t e;
                g = golden(64, a_in[0], b_in[0], cin_w[0], sub_w[0]);
                e.idx     = 0;
                e.sum     = g[63:0];
                e.co      = g[64];
                e.ov      = g[65];
                e.exp_cyc = cyc + 1 + 4;
                e.name    = "handshake";
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start_w[0] = 1'b0;
        wait_drain();
        hs_mode = 1'b0;

        // reset asserted while the second chunk is in RUN
        apply_stimulus(0, 64'h1111_2222_3333_4444, 64'd0, 1'b0, 1'b0,
                       64'd0, 1'b0, 1'b0, "aborted", 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_output("abort_sum", sum_w[0], 64'd0);
        check_output("abort_carry", {63'd0, co_w[0]}, 64'd0);
        check_output("abort_ovf", {63'd0, ov_w[0]}, 64'd0);
        check_output("abort_ready", {63'd0, ready_w[0]}, 64'd1);
        check_output("abort_done", {63'd0, done_w[0]}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        check_output("release_done", {63'd0, done_w[0]}, 64'd0);
        apply_stimulus(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h0000_0001_0000_0000, 1'b0, 1'b0, "after_reset", 1'b1);
        wait_drain();

        // single-chunk instance: one RUN cycle
        apply_stimulus(1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h0000_0001_0000_0000, 1'b0, 1'b0, "c64_add", 1'b1);
        wait_drain();
        apply_stimulus(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h8000_0000_0000_0000, 1'b0, 1'b1, "c64_ovf", 1'b1);
        wait_drain();

        // 32/8 instance: directed then random against the golden model
        apply_stimulus(2, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b0,
                       64'h0000_0000_8000_0000, 1'b0, 1'b1, "w32_ovf", 1'b1);
        wait_drain();
        for (int k = 0; k < 8; k++) begin
            ra = {32'd0, $urandom};
            rb = {32'd0, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            g  = golden(32, ra, rb, rc, rs);
            apply_stimulus(2, ra, rb, rc, rs, g[63:0], g[64], g[65], "w32_rand", 1'b1);
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor. It is the next-generation replacement for the fixed-width cascaded ripple-carry adders in the ALU datapath. An operand pair of WIDTH bits is accepted on a start/ready handshake and processed CHUNK bits per clock, with the carry held in a register between chunks. This trades latency for a short critical path and adds a subtract mode and a signed-overflow flag.

## Interface
- WIDTH, default 64: operand/result width; WIDTH % CHUNK == 0 required.
- CHUNK, default 16: bits added per cycle; NCHUNK = WIDTH/CHUNK, must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready = 1.
- ready  output  1  block is idle and will accept start.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- carry_in  input  1  carry/borrow in; sampled on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; sampled on the accepting edge.
- sum  output  WIDTH  result register.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed (two's-complement) overflow.
- done  output  1  one-cycle pulse; results valid.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset** (rst low, async) forces:
  - state = IDLE, ready = 1, done = 0, sum = 0, carry_out = 0, overflow = 0;
  - chunk counter = 0, internal carry = 0.
- **IDLE, start = 1:**
  - latch a into A_reg;
  - latch b XOR {WIDTH{sub}} into B_reg;
  - latch carry_in XOR sub into carry_reg;
  - go to RUN, ready = 0, counter = 0.
- **Effective operation:**
  - sub = 0: a + b + carry_in;
  - sub = 1: a − b − carry_in (borrow semantics).
- **RUN, per cycle:**
  - {c, s} = A_reg[CHUNK-1:0] + B_reg[CHUNK-1:0] + carry_reg;
  - s is written into sum chunk[counter];
  - carry_reg = c;
  - A_reg and B_reg shift right by CHUNK;
  - counter increments.
- **Last chunk** (counter = NCHUNK-1): in the same cycle,
  - carry_out = c;
  - overflow = (carry into bit WIDTH-1) XOR c;
  - go to DONE.
- **DONE:** done = 1 for exactly one cycle, ready = 0; next state is IDLE.
- **Hold:** sum, carry_out and overflow hold their values until the next accepted start. During RUN, sum is partially updated and is not valid.
- **start while not ready:** ignored, with no queuing; operands must be re-presented.
- **Input changes:** a, b, carry_in and sub may change freely after the accepting edge.
- **sub = 1, carry_out meaning:** carry_out = NOT borrow, so 1 means a ≥ b + carry_in (unsigned).
- **NCHUNK = 1:** RUN lasts one cycle; the last-chunk rules apply to chunk 0.

## Timing
- **Latency:** start is accepted at edge E0. Chunk i is computed at edge E0+1+i. Results are registered at edge E0+NCHUNK, with done high and ready low in the following cycle. ready returns high at edge E0+NCHUNK+1.
- **Throughput:** one operation per NCHUNK+2 cycles. The earliest next accept is the edge where ready is already high.
- **Critical path:** one CHUNK-bit ripple add plus mux; no WIDTH-bit combinational carry chain.
- **Reset mid-operation:** the operation is aborted immediately. Outputs take reset values, and done never pulses for the aborted operation.
- **Reset release:** the first start can be accepted on the first rising edge after rst goes high.

## Test plan
- **Add, WIDTH=64, CHUNK=16:** a=0x0000_0000_FFFF_FFFF, b=1, sub=0, cin=0 → sum=0x0000_0001_0000_0000, carry_out=0, overflow=0. done pulses exactly 4 cycles after the accept edge (carry crosses two chunk boundaries).
- **Full wrap:** a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, carry_out=1, overflow=0.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
- **Subtract:**
  - a=5, b=7, sub=1, cin=0 → sum=0xFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow), overflow=0;
  - a=7, b=5, sub=1, cin=1 → sum=1, carry_out=1.
- **Handshake:** hold start=1 continuously with changing operands. Only operands present when ready=1 are used, each done is a single cycle, and the spacing between dones is 6 cycles.
- **Reset and parameter sweep:**
  - assert rst low during RUN of the second chunk → all outputs zero and ready=1 asynchronously, with no done pulse;
  - repeat the first scenario with CHUNK=64 (latency 1 RUN cycle) and WIDTH=32, CHUNK=8 using random operands checked against a golden model.
